// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - program counter and hardware return stack for the PIC16F1826 core
// Define STACK_ERR_EN to add the occupancy count and sticky overflow/underflow flags.
module pc_stack_unit #(
    parameter int              AW      = 11,
    parameter int              DEPTH   = 16,
    parameter logic [AW-1:0]   RST_VEC = '0,
    parameter logic [AW-1:0]   IRQ_VEC = AW'(4)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pc_en,
    input  logic [2:0]    pc_op,
    input  logic [AW-1:0] k_addr,
    input  logic [8:0]    rel_off,
    input  logic          irq,
    output logic [AW-1:0] pc_out,
    output logic [4:0]    stk_ptr,
    output logic          stk_ovf,
    output logic          stk_unf
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_SKIP = 3'd1;
    localparam logic [2:0] OP_GOTO = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_BRA  = 3'd5;
    localparam logic [2:0] OP_HOLD = 3'd6;

    logic [AW-1:0] pc_q, pc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] stack_q [DEPTH];

    logic          push_req, pop_req;
    logic          do_push, do_pop;
    logic [AW-1:0] push_data, pc_tgt, pc_inc, pop_data;
    logic [PW-1:0] rd_idx;

    assign pc_inc   = pc_q + AW'(1);
    assign rd_idx   = ptr_q - PW'(1);
    assign pop_data = stack_q[rd_idx];

    // Decode the requested control transfer; irq outranks whatever the decoder asked for.
    always_comb begin
        push_req  = 1'b0;
        pop_req   = 1'b0;
        push_data = pc_inc;
        pc_tgt    = pc_inc;
        if (irq) begin
            push_req  = 1'b1;
            push_data = pc_q;
            pc_tgt    = IRQ_VEC;
        end else begin
            case (pc_op)
                OP_INC:  pc_tgt = pc_inc;
                OP_SKIP: pc_tgt = pc_q + AW'(2);
                OP_GOTO: pc_tgt = k_addr;
                OP_CALL: begin
                    push_req = 1'b1;
                    pc_tgt   = k_addr;
                end
                OP_RET: begin
                    pop_req = 1'b1;
                    pc_tgt  = pop_data;
                end
                OP_BRA:  pc_tgt = pc_inc + AW'($signed(rel_off));
                OP_HOLD: pc_tgt = pc_q;
                default: pc_tgt = pc_inc;
            endcase
        end
    end

`ifdef STACK_ERR_EN
    logic [PW:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d, unf_q, unf_d;
    logic        full, empty;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        do_push = pc_en && push_req && !full;
        do_pop  = pc_en && pop_req && !empty;
        ovf_d   = ovf_q | (pc_en && push_req && full);
        unf_d   = unf_q | (pc_en && pop_req && empty);
        cnt_d   = cnt_q;
        if (do_push) cnt_d = cnt_q + (PW+1)'(1);
        if (do_pop)  cnt_d = cnt_q - (PW+1)'(1);
        pc_d = pc_q;
        if (pc_en) pc_d = (pop_req && empty) ? RST_VEC : pc_tgt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
`else
    // Circular stack: pointer simply wraps, overflow silently overwrites the oldest entry.
    always_comb begin
        do_push = pc_en && push_req;
        do_pop  = pc_en && pop_req;
        pc_d    = pc_en ? pc_tgt : pc_q;
    end

    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

    always_comb begin
        ptr_d = ptr_q;
        if (do_push) ptr_d = ptr_q + PW'(1);
        if (do_pop)  ptr_d = rd_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RST_VEC;
            ptr_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) stack_q[ptr_q] <= push_data;
    end

    assign pc_out  = pc_q;
    assign stk_ptr = 5'(ptr_q);
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed vector bench for pc_stack_unit
module tb_pc_stack_unit;
    localparam logic [2:0] INC = 3'd0, SKIP = 3'd1, GOTO = 3'd2, CALL = 3'd3;
    localparam logic [2:0] RET = 3'd4, BRA = 3'd5, HOLD = 3'd6, INC7 = 3'd7;

    logic        clk = 1'b0;
    logic        rst, pc_en, irq;
    logic [2:0]  pc_op;
    logic [10:0] k_addr;
    logic [8:0]  rel_off;
    logic [10:0] pc_out;
    logic [4:0]  stk_ptr;
    logic        stk_ovf, stk_unf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic [2:0]  op;
        logic [10:0] k;
        logic [8:0]  rel;
        logic        irq;
        logic [10:0] exp_pc;
        logic [4:0]  exp_ptr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pc_stack_unit dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .pc_op(pc_op), .k_addr(k_addr),
        .rel_off(rel_off), .irq(irq), .pc_out(pc_out), .stk_ptr(stk_ptr),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic [2:0] op, input logic [10:0] k,
                       input logic [8:0] rel, input logic i, input logic [10:0] epc, input logic [4:0] eptr);
        vecs.push_back('{r, e, op, k, rel, i, epc, eptr});
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] op, input logic [10:0] k,
                        input logic [8:0] rel, input logic i);
        rst = r; pc_en = e; pc_op = op; k_addr = k; rel_off = rel; irq = i;
        @(posedge clk);
        #1;
    endtask

    logic [10:0] ra [1:17];
    logic [10:0] tgt;
    logic        err_mode;

    initial begin
`ifdef STACK_ERR_EN
        err_mode = 1'b1;
`else
        err_mode = 1'b0;
`endif
        add(1, 1, INC,  11'h000, 9'h000, 0, 11'h000, 5'd0);
        for (int i = 1; i <= 5; i++) add(0, 1, INC, 11'h000, 9'h000, 0, 11'(i), 5'd0);
        add(0, 1, GOTO, 11'h010, 9'h000, 0, 11'h010, 5'd0);
        add(0, 1, CALL, 11'h100, 9'h000, 0, 11'h100, 5'd1);
        add(0, 1, RET,  11'h000, 9'h000, 0, 11'h011, 5'd0);
        add(0, 1, GOTO, 11'h020, 9'h000, 0, 11'h020, 5'd0);
        add(0, 1, BRA,  11'h000, 9'h1FD, 0, 11'h01E, 5'd0);
        add(0, 1, GOTO, 11'h7FF, 9'h000, 0, 11'h7FF, 5'd0);
        add(0, 1, INC,  11'h000, 9'h000, 0, 11'h000, 5'd0);
        add(0, 1, GOTO, 11'h7FF, 9'h000, 0, 11'h7FF, 5'd0);
        add(0, 1, SKIP, 11'h000, 9'h000, 0, 11'h001, 5'd0);
        add(0, 1, GOTO, 11'h016, 9'h000, 0, 11'h016, 5'd0);
        add(0, 1, CALL, 11'h300, 9'h000, 1, 11'h004, 5'd1);
        add(0, 1, RET,  11'h000, 9'h000, 0, 11'h016, 5'd0);
        add(0, 1, HOLD, 11'h000, 9'h000, 0, 11'h016, 5'd0);
        add(0, 1, INC7, 11'h000, 9'h000, 0, 11'h017, 5'd0);
        for (int i = 0; i < 3; i++) add(0, 0, GOTO, 11'h555, 9'h000, 1, 11'h017, 5'd0);
        add(0, 1, BRA,  11'h000, 9'h0FF, 0, 11'h117, 5'd0);
        add(0, 1, BRA,  11'h000, 9'h100, 0, 11'h018, 5'd0);
        add(0, 1, CALL, 11'h200, 9'h000, 0, 11'h200, 5'd1);
        add(1, 1, CALL, 11'h400, 9'h000, 0, 11'h000, 5'd0);
        add(0, 1, GOTO, 11'h7FE, 9'h000, 0, 11'h7FE, 5'd0);
        add(0, 1, BRA,  11'h000, 9'h002, 0, 11'h001, 5'd0);

        foreach (vecs[n]) begin
            step(vecs[n].rst, vecs[n].en, vecs[n].op, vecs[n].k, vecs[n].rel, vecs[n].irq);
            check($sformatf("vec%0d_pc", n), 32'(pc_out), 32'(vecs[n].exp_pc));
            check($sformatf("vec%0d_ptr", n), 32'(stk_ptr), 32'(vecs[n].exp_ptr));
            check($sformatf("vec%0d_ovf", n), 32'(stk_ovf), 32'd0);
            check($sformatf("vec%0d_unf", n), 32'(stk_unf), 32'd0);
        end

        // 17 nested calls from pc 0x001; return address of call i is ra[i]
        for (int i = 1; i <= 17; i++) begin
            ra[i] = (i == 1) ? 11'h002 : (11'h100 + 11'((i - 1) * 16) + 11'h001);
            tgt   = 11'h100 + 11'(i * 16);
            step(0, 1, CALL, tgt, 9'h000, 0);
            check($sformatf("call%0d_pc", i), 32'(pc_out), 32'(tgt));
            check($sformatf("call%0d_ptr", i), 32'(stk_ptr),
                  (err_mode && i == 17) ? 32'd0 : 32'(i % 16));
        end
        check("ovf_after_call17", 32'(stk_ovf), 32'(err_mode));

        for (int j = 1; j <= 17; j++) begin
            step(0, 1, RET, 11'h000, 9'h000, 0);
            if (err_mode) begin
                check($sformatf("ret%0d_pc", j), 32'(pc_out), (j == 17) ? 32'd0 : 32'(ra[17 - j]));
                check($sformatf("ret%0d_ptr", j), 32'(stk_ptr), (j == 17) ? 32'd0 : 32'((16 - j) % 16));
            end else begin
                check($sformatf("ret%0d_pc", j), 32'(pc_out), (j == 17) ? 32'(ra[17]) : 32'(ra[18 - j]));
                check($sformatf("ret%0d_ptr", j), 32'(stk_ptr), 32'((17 - j) % 16));
            end
        end
        check("unf_after_ret17", 32'(stk_unf), 32'(err_mode));
        check("ovf_sticky", 32'(stk_ovf), 32'(err_mode));

        // flags must survive a frozen pipeline and clear only on reset
        step(0, 0, RET, 11'h000, 9'h000, 1);
        check("hold_ovf", 32'(stk_ovf), 32'(err_mode));
        check("hold_unf", 32'(stk_unf), 32'(err_mode));
        step(1, 1, INC, 11'h000, 9'h000, 0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_ovf", 32'(stk_ovf), 32'd0);
        check("rst_unf", 32'(stk_unf), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
